// File: rtl/axi3_rr_arbiter_if.sv
// Bus bundles for the N-master to 1-slave AXI3 arbiter.
// axi3_rr_up_if carries the upstream (client) side: all masters packed into vectors.
// axi3_rr_dn_if carries the single downstream AXI3 port.

interface axi3_rr_up_if #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int AB = ADDR_W + 11;
  localparam int WB = DATA_W + DATA_W/8 + 1;

  logic [N_MASTERS-1:0]    m_ar_valid;
  logic [N_MASTERS-1:0]    m_ar_ready;
  logic [N_MASTERS*AB-1:0] m_ar_bits;
  logic [N_MASTERS-1:0]    m_r_valid;
  logic [N_MASTERS-1:0]    m_r_ready;
  logic [DATA_W+2:0]       m_r_bits;
  logic [N_MASTERS-1:0]    m_aw_valid;
  logic [N_MASTERS-1:0]    m_aw_ready;
  logic [N_MASTERS*AB-1:0] m_aw_bits;
  logic [N_MASTERS-1:0]    m_w_valid;
  logic [N_MASTERS-1:0]    m_w_ready;
  logic [N_MASTERS*WB-1:0] m_w_bits;
  logic [N_MASTERS-1:0]    m_b_valid;
  logic [N_MASTERS-1:0]    m_b_ready;
  logic [1:0]              m_b_resp;

  modport master (
    output m_ar_valid, m_ar_bits, m_r_ready, m_aw_valid, m_aw_bits,
           m_w_valid, m_w_bits, m_b_ready,
    input  m_ar_ready, m_r_valid, m_r_bits, m_aw_ready, m_w_ready,
           m_b_valid, m_b_resp
  );

  modport slave (
    input  m_ar_valid, m_ar_bits, m_r_ready, m_aw_valid, m_aw_bits,
           m_w_valid, m_w_bits, m_b_ready,
    output m_ar_ready, m_r_valid, m_r_bits, m_aw_ready, m_w_ready,
           m_b_valid, m_b_resp
  );
endinterface

interface axi3_rr_dn_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     axi_arid;
  logic [ADDR_W-1:0]   axi_araddr;
  logic [7:0]          axi_arlen;
  logic [2:0]          axi_arsize;
  logic [1:0]          axi_arburst;
  logic [1:0]          axi_arlock;
  logic [3:0]          axi_arcache;
  logic [2:0]          axi_arprot;
  logic                axi_arvalid;
  logic                axi_arready;

  logic [ID_W-1:0]     axi_rid;
  logic [DATA_W-1:0]   axi_rdata;
  logic [1:0]          axi_rresp;
  logic                axi_rlast;
  logic                axi_rvalid;
  logic                axi_rready;

  logic [ID_W-1:0]     axi_awid;
  logic [ADDR_W-1:0]   axi_awaddr;
  logic [7:0]          axi_awlen;
  logic [2:0]          axi_awsize;
  logic [1:0]          axi_awburst;
  logic [1:0]          axi_awlock;
  logic [3:0]          axi_awcache;
  logic [2:0]          axi_awprot;
  logic                axi_awvalid;
  logic                axi_awready;

  logic [ID_W-1:0]     axi_wid;
  logic [DATA_W-1:0]   axi_wdata;
  logic [DATA_W/8-1:0] axi_wstrb;
  logic                axi_wlast;
  logic                axi_wvalid;
  logic                axi_wready;

  logic [ID_W-1:0]     axi_bid;
  logic [1:0]          axi_bresp;
  logic                axi_bvalid;
  logic                axi_bready;

  modport master (
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
           axi_arcache, axi_arprot, axi_arvalid, axi_rready,
           axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
           axi_awcache, axi_awprot, axi_awvalid,
           axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
    input  axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
           axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid
  );

  modport slave (
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
           axi_arcache, axi_arprot, axi_arvalid, axi_rready,
           axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
           axi_awcache, axi_awprot, axi_awvalid,
           axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
    output axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
           axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid
  );
endinterface

// File: rtl/axi3_rr_arbiter.sv
// N-master to 1-slave AXI3 arbiter. Read and write paths arbitrate independently
// with round-robin pointers; each downstream burst carries ID = master index and
// R/B beats are routed back by ID. Unknown IDs are sunk.

module axi3_rr_arbiter #(
  parameter int N_MASTERS = 3,
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic          clock,
  input  logic          reset,
  axi3_rr_up_if.slave   up,
  axi3_rr_dn_if.master  dn
);

  localparam int AB = ADDR_W + 11;
  localparam int WB = DATA_W + DATA_W/8 + 1;
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_MASTERS - 1);

  typedef enum logic       {AR_IDLE, AR_SEND}                 ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_BOTH, W_DATA, W_ADDR}   w_state_t;

  // First requester at or after the pointer, wrapping.
  function automatic logic [ID_W-1:0] f_rr_pick(input logic [N_MASTERS-1:0] i_req,
                                                input logic [ID_W-1:0]      i_ptr);
    logic [2*N_MASTERS-1:0] v_rot;
    logic [ID_W-1:0]        v_sel;
    logic                   v_found;
    int unsigned            v_idx;
    v_rot   = {i_req, i_req} >> i_ptr;
    v_sel   = '0;
    v_found = 1'b0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (!v_found && v_rot[k]) begin
        v_found = 1'b1;
        v_idx   = 32'(i_ptr) + k;
        if (v_idx >= 32'(N_MASTERS)) v_idx = v_idx - 32'(N_MASTERS);
        v_sel   = ID_W'(v_idx);
      end
    end
    return v_sel;
  endfunction

  function automatic logic [ID_W-1:0] f_next(input logic [ID_W-1:0] i_g);
    return (i_g == LAST_IDX) ? '0 : i_g + ID_W'(1);
  endfunction

  // ---------------- read path ----------------
  ar_state_t           r_ar_state;
  logic                r_arvalid;
  logic [ID_W-1:0]     r_arid;
  logic [ADDR_W-1:0]   r_araddr;
  logic [7:0]          r_arlen;
  logic [2:0]          r_arsize;
  logic [ID_W-1:0]     r_rd_ptr;
  logic [ID_W-1:0]     w_ar_pick;
  logic [AB-1:0]       w_ar_sel;

  assign w_ar_pick = f_rr_pick(up.m_ar_valid, r_rd_ptr);

  // Mux the request fields of the master the pointer would grant.
  always_comb begin
    w_ar_sel = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++)
      if (w_ar_pick == ID_W'(i)) w_ar_sel = up.m_ar_bits[i*AB +: AB];
  end

  // Read address FSM: capture a grant, hold AR until accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ar_state <= AR_IDLE;
      r_arvalid  <= 1'b0;
      r_arid     <= '0;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_arsize   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      case (r_ar_state)
        AR_IDLE: begin
          if (|up.m_ar_valid) begin
            r_arid                         <= w_ar_pick;
            {r_araddr, r_arlen, r_arsize}  <= w_ar_sel;
            r_arvalid                      <= 1'b1;
            r_ar_state                     <= AR_SEND;
          end
        end
        AR_SEND: begin
          if (dn.axi_arready) begin
            r_arvalid  <= 1'b0;
            r_rd_ptr   <= f_next(r_arid);
            r_ar_state <= AR_IDLE;
          end
        end
        default: r_ar_state <= AR_IDLE;
      endcase
    end
  end

  assign dn.axi_arid    = r_arid;
  assign dn.axi_araddr  = r_araddr;
  assign dn.axi_arlen   = r_arlen;
  assign dn.axi_arsize  = r_arsize;
  assign dn.axi_arvalid = r_arvalid;
  assign dn.axi_arburst = 2'b01;
  assign dn.axi_arlock  = '0;
  assign dn.axi_arcache = '0;
  assign dn.axi_arprot  = '0;

  // Upstream accept coincides with the downstream AR handshake, so the master
  // drops valid before the FSM is back in AR_IDLE and cannot be re-granted.
  always_comb begin
    up.m_ar_ready = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++)
      up.m_ar_ready[i] = r_arvalid && dn.axi_arready && (r_arid == ID_W'(i));
  end

  // R beats steered by rid; unknown rid is accepted and dropped.
  always_comb begin
    up.m_r_valid  = '0;
    dn.axi_rready = 1'b1;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (dn.axi_rid == ID_W'(i)) begin
        up.m_r_valid[i] = dn.axi_rvalid;
        dn.axi_rready   = up.m_r_ready[i];
      end
    end
  end

  assign up.m_r_bits = {dn.axi_rdata, dn.axi_rresp, dn.axi_rlast};

  // ---------------- write path ----------------
  w_state_t            r_w_state;
  logic                r_awvalid;
  logic [ID_W-1:0]     r_wg;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [7:0]          r_awlen;
  logic [2:0]          r_awsize;
  logic [ID_W-1:0]     r_wr_ptr;
  logic [ID_W-1:0]     w_aw_pick;
  logic [AB-1:0]       w_aw_sel;
  logic [WB-1:0]       w_wsel;
  logic                w_wfwd;
  logic                w_aw_hs;
  logic                w_wl_hs;

  assign w_aw_pick = f_rr_pick(up.m_aw_valid, r_wr_ptr);
  assign w_wfwd    = (r_w_state == W_BOTH) || (r_w_state == W_DATA);
  assign w_aw_hs   = r_awvalid && dn.axi_awready;
  assign w_wl_hs   = dn.axi_wvalid && dn.axi_wready && dn.axi_wlast;

  // Field muxes: AW candidate from the pointer, W data from the current grant.
  always_comb begin
    w_aw_sel = '0;
    w_wsel   = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (w_aw_pick == ID_W'(i)) w_aw_sel = up.m_aw_bits[i*AB +: AB];
      if (r_wg == ID_W'(i))      w_wsel   = up.m_w_bits[i*WB +: WB];
    end
  end

  // Write FSM: AW and the W burst may complete in either order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_w_state <= W_IDLE;
      r_awvalid <= 1'b0;
      r_wg      <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_wr_ptr  <= '0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (|up.m_aw_valid) begin
            r_wg                           <= w_aw_pick;
            {r_awaddr, r_awlen, r_awsize}  <= w_aw_sel;
            r_awvalid                      <= 1'b1;
            r_wr_ptr                       <= f_next(w_aw_pick);
            r_w_state                      <= W_BOTH;
          end
        end
        W_BOTH: begin
          if (w_aw_hs && w_wl_hs) begin
            r_awvalid <= 1'b0;
            r_w_state <= W_IDLE;
          end else if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_w_state <= W_DATA;
          end else if (w_wl_hs) begin
            r_w_state <= W_ADDR;
          end
        end
        W_DATA: begin
          if (w_wl_hs) r_w_state <= W_IDLE;
        end
        W_ADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_w_state <= W_IDLE;
          end
        end
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

  assign dn.axi_awid    = r_wg;
  assign dn.axi_awaddr  = r_awaddr;
  assign dn.axi_awlen   = r_awlen;
  assign dn.axi_awsize  = r_awsize;
  assign dn.axi_awvalid = r_awvalid;
  assign dn.axi_awburst = 2'b01;
  assign dn.axi_awlock  = '0;
  assign dn.axi_awcache = '0;
  assign dn.axi_awprot  = '0;

  assign dn.axi_wid = r_wg;
  assign {dn.axi_wdata, dn.axi_wstrb, dn.axi_wlast} = w_wsel;

  // W handshake passes straight through for the granted master only.
  always_comb begin
    dn.axi_wvalid = 1'b0;
    up.m_w_ready  = '0;
    up.m_aw_ready = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (r_wg == ID_W'(i)) begin
        dn.axi_wvalid    = w_wfwd && up.m_w_valid[i];
        up.m_w_ready[i]  = w_wfwd && dn.axi_wready;
        up.m_aw_ready[i] = w_aw_hs;
      end
    end
  end

  // B responses steered by bid; unknown bid is sunk.
  always_comb begin
    up.m_b_valid  = '0;
    dn.axi_bready = 1'b1;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (dn.axi_bid == ID_W'(i)) begin
        up.m_b_valid[i] = dn.axi_bvalid;
        dn.axi_bready   = up.m_b_ready[i];
      end
    end
  end

  assign up.m_b_resp = dn.axi_bresp;

endmodule

// File: tb/tb_axi3_rr_arbiter.sv
// Directed bench for axi3_rr_arbiter with N_MASTERS=3.

module tb_axi3_rr_arbiter;
  localparam int N  = 3;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int AB = AW + 11;
  localparam int WB = DW + DW/8 + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi3_rr_up_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) up();
  axi3_rr_dn_if #(.ID_W(IW), .ADDR_W(AW), .DATA_W(DW))     dn();

  axi3_rr_arbiter #(.N_MASTERS(N), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .up    (up),
    .dn    (dn)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic set_ar(input int unsigned i, input logic [31:0] a, input logic [7:0] l);
    up.m_ar_bits[i*AB +: AB] = {a, l, 3'd2};
  endtask

  task automatic set_aw(input int unsigned i, input logic [31:0] a, input logic [7:0] l);
    up.m_aw_bits[i*AB +: AB] = {a, l, 3'd2};
  endtask

  task automatic set_w(input int unsigned i, input logic [31:0] d, input logic last);
    up.m_w_bits[i*WB +: WB] = {d, 4'hF, last};
  endtask

  // Collect n AR grants (arready held 1); masters drop valid once accepted.
  task automatic run_ar(input int unsigned n, input logic [31:0] seq);
    int unsigned     k = 0;
    logic [N-1:0]    rel;
    logic [IW-1:0]   e;
    for (int c = 0; c < 40 && k < n; c++) begin
      @(negedge clock);
      rel = '0;
      if (dn.axi_arvalid) begin
        e = seq[k*4 +: 4];
        check("arid", dn.axi_arid, e);
        check("araddr", dn.axi_araddr, 32'h1000 * (e + 1));
        check("arlen", dn.axi_arlen, {4'd0, e});
        check("m_ar_ready", up.m_ar_ready, 3'b001 << e);
        rel = up.m_ar_ready;
        k++;
      end
      @(posedge clock);
      #1;
      up.m_ar_valid = up.m_ar_valid & ~rel;
    end
    check("ar_count", k, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned b;
    logic        tg;

    up.m_ar_valid = '0; up.m_ar_bits = '0; up.m_r_ready = '0;
    up.m_aw_valid = '0; up.m_aw_bits = '0; up.m_w_valid = '0;
    up.m_w_bits   = '0; up.m_b_ready = '0;
    dn.axi_arready = 1'b0; dn.axi_awready = 1'b0; dn.axi_wready = 1'b0;
    dn.axi_rid = '0; dn.axi_rdata = '0; dn.axi_rresp = '0; dn.axi_rlast = 1'b0;
    dn.axi_rvalid = 1'b0; dn.axi_bid = '0; dn.axi_bresp = '0; dn.axi_bvalid = 1'b0;
    for (int unsigned i = 0; i < N; i++) set_ar(i, 32'h1000 * (i + 1), 8'(i));

    // Reset state
    #1;
    check("rst_arvalid", dn.axi_arvalid, 0);
    check("rst_awvalid", dn.axi_awvalid, 0);
    check("rst_m_ar_ready", up.m_ar_ready, 0);
    check("rst_m_w_ready", up.m_w_ready, 0);
    check("rst_m_r_valid", up.m_r_valid, 0);
    check("rst_m_b_valid", up.m_b_valid, 0);
    tick();
    reset = 1'b0;

    // Round robin: all three request together, twice
    dn.axi_arready = 1'b1;
    up.m_ar_valid = 3'b111;
    run_ar(3, 32'h0000_0210);
    up.m_ar_valid = 3'b111;
    run_ar(3, 32'h0000_0210);
    check("arburst", dn.axi_arburst, 2'b01);

    // Latency: one cycle from m_ar_valid to axi_arvalid
    up.m_ar_valid = 3'b001;
    mid();
    check("ar_lat_idle", dn.axi_arvalid, 0);
    tick(); mid();
    check("ar_lat_send", dn.axi_arvalid, 1);
    check("ar_lat_id", dn.axi_arid, 0);
    check("ar_lat_ready", up.m_ar_ready, 3'b001);
    tick();
    up.m_ar_valid = 3'b000;

    // Reset in the middle of AR_SEND; pointer was 1 before reset
    dn.axi_arready = 1'b0;
    up.m_ar_valid = 3'b100;
    tick(); mid();
    check("pre_rst_arvalid", dn.axi_arvalid, 1);
    check("pre_rst_arid", dn.axi_arid, 2);
    reset = 1'b1;
    #1;
    check("mid_rst_arvalid", dn.axi_arvalid, 0);
    tick();
    reset = 1'b0;
    up.m_ar_valid = 3'b011;
    dn.axi_arready = 1'b1;
    run_ar(2, 32'h0000_0010);

    // R burst on rid=1, len=3, with master 1 ready toggling
    b = 0;
    tg = 1'b0;
    dn.axi_rid = 4'd1;
    for (int c = 0; c < 20 && b < 4; c++) begin
      dn.axi_rvalid = 1'b1;
      dn.axi_rdata  = 32'hA0 + b;
      dn.axi_rresp  = 2'b00;
      dn.axi_rlast  = (b == 3);
      up.m_r_ready  = {1'b1, tg, 1'b1};
      mid();
      check("r_valid_onehot", up.m_r_valid, 3'b010);
      check("r_ready_follow", dn.axi_rready, tg);
      if (tg) begin
        check("r_bits", up.m_r_bits, {32'hA0 + b, 2'b00, (b == 3)});
        b++;
      end
      tick();
      tg = ~tg;
    end
    check("r_beats", b, 4);
    dn.axi_rvalid = 1'b0;

    // Stray rid=7 is sunk
    dn.axi_rid = 4'd7;
    dn.axi_rvalid = 1'b1;
    up.m_r_ready = 3'b000;
    #1;
    check("stray_rready", dn.axi_rready, 1);
    check("stray_r_valid", up.m_r_valid, 0);
    dn.axi_rvalid = 1'b0;
    dn.axi_rid = '0;
    tick();

    // Master 2 write len=1, wlast accepted 3 cycles before awready
    dn.axi_awready = 1'b0;
    dn.axi_wready  = 1'b1;
    set_aw(2, 32'h3000, 8'd1);
    up.m_aw_valid = 3'b100;
    set_w(2, 32'hD0, 1'b0);
    up.m_w_valid = 3'b100;
    mid();
    check("w_idle_awvalid", dn.axi_awvalid, 0);
    check("w_idle_wvalid", dn.axi_wvalid, 0);
    tick(); mid();
    check("w_both_awvalid", dn.axi_awvalid, 1);
    check("w_awid", dn.axi_awid, 2);
    check("w_awaddr", dn.axi_awaddr, 32'h3000);
    check("w_awlen", dn.axi_awlen, 1);
    check("w_wvalid0", dn.axi_wvalid, 1);
    check("w_wid", dn.axi_wid, 2);
    check("w_wdata0", dn.axi_wdata, 32'hD0);
    check("w_wlast0", dn.axi_wlast, 0);
    check("w_m_w_ready0", up.m_w_ready, 3'b100);
    check("w_aw_ready_early0", up.m_aw_ready, 0);
    tick();
    set_w(2, 32'hD1, 1'b1);
    mid();
    check("w_wvalid1", dn.axi_wvalid, 1);
    check("w_wdata1", dn.axi_wdata, 32'hD1);
    check("w_wlast1", dn.axi_wlast, 1);
    check("w_m_w_ready1", up.m_w_ready, 3'b100);
    check("w_aw_ready_early1", up.m_aw_ready, 0);
    tick();
    set_w(2, 32'hEE, 1'b0);
    for (int j = 0; j < 2; j++) begin
      mid();
      check("w_addr_awvalid", dn.axi_awvalid, 1);
      check("w_addr_nofwd", dn.axi_wvalid, 0);
      check("w_addr_m_w_ready", up.m_w_ready, 0);
      check("w_addr_aw_ready", up.m_aw_ready, 0);
      tick();
    end
    dn.axi_awready = 1'b1;
    mid();
    check("w_aw_pulse", up.m_aw_ready, 3'b100);
    tick();
    dn.axi_awready = 1'b0;
    up.m_aw_valid = 3'b000;
    up.m_w_valid = 3'b000;
    mid();
    check("w_done_awvalid", dn.axi_awvalid, 0);
    check("w_done_aw_ready", up.m_aw_ready, 0);
    tick();

    // Concurrent read by master 0 and write by master 1
    dn.axi_arready = 1'b1;
    dn.axi_awready = 1'b1;
    dn.axi_wready  = 1'b1;
    up.m_ar_valid  = 3'b001;
    set_aw(1, 32'h5000, 8'd0);
    up.m_aw_valid  = 3'b010;
    set_w(1, 32'hBEEF, 1'b1);
    up.m_w_valid   = 3'b010;
    tick(); mid();
    check("cc_arvalid", dn.axi_arvalid, 1);
    check("cc_arid", dn.axi_arid, 0);
    check("cc_awvalid", dn.axi_awvalid, 1);
    check("cc_awid", dn.axi_awid, 1);
    check("cc_wid", dn.axi_wid, 1);
    check("cc_wdata", dn.axi_wdata, 32'hBEEF);
    check("cc_wvalid", dn.axi_wvalid, 1);
    check("cc_m_ar_ready", up.m_ar_ready, 3'b001);
    check("cc_m_aw_ready", up.m_aw_ready, 3'b010);
    check("cc_m_w_ready", up.m_w_ready, 3'b010);
    tick();
    up.m_ar_valid = 3'b000;
    set_aw(0, 32'h6000, 8'd0);
    up.m_aw_valid = 3'b001;
    set_w(0, 32'h600D, 1'b1);
    up.m_w_valid  = 3'b001;
    dn.axi_awready = 1'b0;
    mid();
    check("cc_ar_idle", dn.axi_arvalid, 0);
    check("cc_w_idle", dn.axi_awvalid, 0);
    tick(); mid();
    check("cc_next_awvalid", dn.axi_awvalid, 1);
    check("cc_next_awid", dn.axi_awid, 0);
    dn.axi_awready = 1'b1;
    tick();
    up.m_aw_valid = 3'b000;
    up.m_w_valid  = 3'b000;
    dn.axi_awready = 1'b0;

    // Read data for master 0
    dn.axi_rid = 4'd0;
    dn.axi_rvalid = 1'b1;
    up.m_r_ready = 3'b001;
    #1;
    check("cc_r_valid", up.m_r_valid, 3'b001);
    check("cc_rready", dn.axi_rready, 1);
    dn.axi_rvalid = 1'b0;

    // B routing
    dn.axi_bid = 4'd1;
    dn.axi_bresp = 2'b10;
    dn.axi_bvalid = 1'b1;
    up.m_b_ready = 3'b010;
    #1;
    check("b_valid", up.m_b_valid, 3'b010);
    check("b_ready", dn.axi_bready, 1);
    check("b_resp", up.m_b_resp, 2'b10);
    up.m_b_ready = 3'b101;
    #1;
    check("b_ready_hold", dn.axi_bready, 0);
    dn.axi_bid = 4'd5;
    #1;
    check("b_stray_ready", dn.axi_bready, 1);
    check("b_stray_valid", up.m_b_valid, 0);
    dn.axi_bvalid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
